i2c_tmp101_read_sequencer: RTL and testbench

Transaction-level controller that sequences the I2C bit datapath (shift-register data unit plus SCL baud generator) through one complete TMP101 temperature read: START, address byte 8'h91, slave ACK check, two data bytes, master ACK/NACK, STOP. It replaces the phase-1 single-byte control unit in the next lab phase and produces a 12-bit temperature word with a valid strobe. All sequencing is driven from edges of the SCL line, sampled in the system clock domain.

---
 rtl/i2c_tmp101_read_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_i2c_tmp101_read_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tmp101_read_sequencer.sv
`timescale 1ns/1ps
// Transaction sequencer for one TMP101 temperature read over the I2C bit datapath.
// Every bit-level action is timed from synchronised SCL edges in the clock domain.
//
// state    | meaning
// IDLE     | bus released, waiting for a fresh Go edge
// START    | SDA low with SCL high for a half period, then SCL starts
// ADDR     | address byte shifted out, one bit per SCL fall
// ACK_IN   | SDA released, slave acknowledge sampled on SCL rise
// READ_MSB | first data byte shifted in on SCL rises
// ACK_OUT  | master drives ACK (SDA low) for one bit
// READ_LSB | second data byte shifted in on SCL rises
// NACK_OUT | master drives NACK (SDA high) for one bit
// STOP     | SDA low, SCL parked high, SDA raised after a half period
// DONE     | result published (unless the address was NACKed)
module i2c_tmp101_read_sequencer #(
    parameter int          ClockFrequency   = 60_000_000,
    parameter int          BaudRate         = 30_000,
    parameter int          HalfPeriodCycles = ClockFrequency / (2 * BaudRate),
    parameter logic [7:0]  SlaveAddress     = 8'b1001_0001
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        Go,
    input  logic        SCL,
    input  logic        SDAin,
    input  logic [7:0]  ReceivedData,
    output logic        BaudEnable,
    output logic        WriteLoad,
    output logic [7:0]  SentData,
    output logic        ShiftorHold,
    output logic        ReadorWrite,
    output logic        Select,
    output logic        StartStopAck,
    output logic [11:0] Temperature,
    output logic        DataValid,
    output logic        AckError,
    output logic        Busy
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_IN,
        READ_MSB,
        ACK_OUT,
        READ_LSB,
        NACK_OUT,
        STOP,
        DONE
    } state_t;

    localparam logic [9:0] HoldLast = 10'(HalfPeriodCycles - 1);

    state_t     state;
    logic [2:0] bit_count;
    logic [9:0] hold_count;
    logic       last_bit;
    logic [7:0] msb_reg;
    logic [3:0] lsb_nibble;

    logic go_q1;
    logic go_q2;
    logic scl_q1;
    logic scl_q2;
    logic go_edge;
    logic scl_rise;
    logic scl_fall;

    assign SentData = SlaveAddress;
    assign go_edge  = go_q1 & ~go_q2;
    assign scl_rise = scl_q1 & ~scl_q2;
    assign scl_fall = ~scl_q1 & scl_q2;

    // SCL synchronisers reset high so a parked line never looks like an edge.
    always_ff @(posedge clock) begin
        if (Reset) begin
            go_q1  <= 1'b0;
            go_q2  <= 1'b0;
            scl_q1 <= 1'b1;
            scl_q2 <= 1'b1;
        end else begin
            go_q1  <= Go;
            go_q2  <= go_q1;
            scl_q1 <= SCL;
            scl_q2 <= scl_q1;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state        <= IDLE;
            bit_count    <= 3'd0;
            hold_count   <= 10'd0;
            last_bit     <= 1'b0;
            msb_reg      <= 8'd0;
            lsb_nibble   <= 4'd0;
            BaudEnable   <= 1'b0;
            WriteLoad    <= 1'b0;
            ShiftorHold  <= 1'b0;
            ReadorWrite  <= 1'b1;
            Select       <= 1'b1;
            StartStopAck <= 1'b1;
            Temperature  <= 12'd0;
            DataValid    <= 1'b0;
            AckError     <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            WriteLoad   <= 1'b0;
            ShiftorHold <= 1'b0;
            DataValid   <= 1'b0;

            case (state)
                IDLE: begin
                    if (go_edge) begin
                        WriteLoad    <= 1'b1;
                        AckError     <= 1'b0;
                        StartStopAck <= 1'b0;
                        hold_count   <= 10'd0;
                        Busy         <= 1'b1;
                        state        <= START;
                    end
                end

                START: begin
                    if (!BaudEnable) begin
                        if (hold_count == HoldLast) begin
                            BaudEnable <= 1'b1;
                        end else begin
                            hold_count <= hold_count + 10'd1;
                        end
                    end else if (scl_fall) begin
                        Select    <= 1'b0;
                        bit_count <= 3'd7;
                        state     <= ADDR;
                    end
                end

                // The shift on the final fall empties the register as SDA is released.
                ADDR: begin
                    if (scl_fall) begin
                        ShiftorHold <= 1'b1;
                        if (bit_count == 3'd0) begin
                            ReadorWrite <= 1'b0;
                            state       <= ACK_IN;
                        end else begin
                            bit_count <= bit_count - 3'd1;
                        end
                    end
                end

                ACK_IN: begin
                    if (scl_rise) begin
                        AckError <= SDAin;
                    end else if (scl_fall) begin
                        if (AckError) begin
                            Select       <= 1'b1;
                            ReadorWrite  <= 1'b1;
                            StartStopAck <= 1'b0;
                            state        <= STOP;
                        end else begin
                            bit_count <= 3'd7;
                            last_bit  <= 1'b0;
                            state     <= READ_MSB;
                        end
                    end
                end

                // last_bit marks that the eighth rise has been seen (bit_count sticks at 0).
                READ_MSB, READ_LSB: begin
                    if (scl_rise) begin
                        ShiftorHold <= 1'b1;
                        if (bit_count != 3'd0) begin
                            bit_count <= bit_count - 3'd1;
                        end else begin
                            last_bit <= 1'b1;
                        end
                    end else if (scl_fall && last_bit) begin
                        last_bit    <= 1'b0;
                        Select      <= 1'b1;
                        ReadorWrite <= 1'b1;
                        if (state == READ_MSB) begin
                            msb_reg      <= ReceivedData;
                            StartStopAck <= 1'b0;
                            state        <= ACK_OUT;
                        end else begin
                            lsb_nibble   <= ReceivedData[7:4];
                            StartStopAck <= 1'b1;
                            state        <= NACK_OUT;
                        end
                    end
                end

                ACK_OUT: begin
                    if (scl_fall) begin
                        Select      <= 1'b0;
                        ReadorWrite <= 1'b0;
                        bit_count   <= 3'd7;
                        last_bit    <= 1'b0;
                        state       <= READ_LSB;
                    end
                end

                NACK_OUT: begin
                    if (scl_fall) begin
                        StartStopAck <= 1'b0;
                        state        <= STOP;
                    end
                end

                STOP: begin
                    if (BaudEnable) begin
                        if (scl_rise) begin
                            BaudEnable <= 1'b0;
                            hold_count <= 10'd0;
                        end
                    end else if (hold_count == HoldLast) begin
                        StartStopAck <= 1'b1;
                        state        <= DONE;
                    end else begin
                        hold_count <= hold_count + 10'd1;
                    end
                end

                DONE: begin
                    if (!AckError) begin
                        Temperature <= {msb_reg, lsb_nibble};
                        DataValid   <= 1'b1;
                    end
                    BaudEnable   <= 1'b0;
                    Select       <= 1'b1;
                    ReadorWrite  <= 1'b1;
                    StartStopAck <= 1'b1;
                    Busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_tmp101_read_sequencer.sv
`timescale 1ns/1ps
// Bench for the TMP101 read sequencer: models the baud generator, the shift-register
// data unit and a TMP101 slave, and scores each completed transaction against a queue.
module tb_i2c_tmp101_read_sequencer;

    localparam int CLK_HZ = 60_000_000;
    localparam int BAUD   = 1_500_000;
    localparam int HALF   = CLK_HZ / (2 * BAUD);

    logic        clock = 1'b0;
    logic        Reset;
    logic        Go;
    logic        SCL = 1'b1;
    logic        SDAin;
    logic [7:0]  ReceivedData;
    logic        BaudEnable;
    logic        WriteLoad;
    logic [7:0]  SentData;
    logic        ShiftorHold;
    logic        ReadorWrite;
    logic        Select;
    logic        StartStopAck;
    logic [11:0] Temperature;
    logic        DataValid;
    logic        AckError;
    logic        Busy;

    i2c_tmp101_read_sequencer #(
        .ClockFrequency(CLK_HZ),
        .BaudRate(BAUD)
    ) dut (
        .clock(clock),
        .Reset(Reset),
        .Go(Go),
        .SCL(SCL),
        .SDAin(SDAin),
        .ReceivedData(ReceivedData),
        .BaudEnable(BaudEnable),
        .WriteLoad(WriteLoad),
        .SentData(SentData),
        .ShiftorHold(ShiftorHold),
        .ReadorWrite(ReadorWrite),
        .Select(Select),
        .StartStopAck(StartStopAck),
        .Temperature(Temperature),
        .DataValid(DataValid),
        .AckError(AckError),
        .Busy(Busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] temp;
        logic        ack_err;
        int          dv;
        int          rises;
        int          sh;
        logic        aborted;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Baud generator and data-unit shift register.
    int         baud_cnt = 0;
    logic [7:0] du_reg = 8'd0;

    always @(posedge clock) begin
        if (Reset || !BaudEnable) begin
            SCL      <= 1'b1;
            baud_cnt <= 0;
        end else if (baud_cnt == HALF - 1) begin
            SCL      <= ~SCL;
            baud_cnt <= 0;
        end else begin
            baud_cnt <= baud_cnt + 1;
        end
        if (Reset)            du_reg <= 8'd0;
        else if (WriteLoad)   du_reg <= SentData;
        else if (ShiftorHold) du_reg <= {du_reg[6:0], SDAin};
    end
    assign ReceivedData = du_reg;

    // Slave: drives ACK on bit 9, MSB on bits 10-17, LSB on bits 19-26.
    logic       slave_ack = 1'b1;
    logic [7:0] slave_msb = 8'd0;
    logic [7:0] slave_lsb = 8'd0;
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    logic       slave_bit;

    always_comb begin
        slave_bit = 1'b1;
        if (fall_cnt == 9)
            slave_bit = ~slave_ack;
        else if (slave_ack && fall_cnt >= 10 && fall_cnt <= 17)
            slave_bit = slave_msb[3'(17 - fall_cnt)];
        else if (slave_ack && fall_cnt >= 19 && fall_cnt <= 26)
            slave_bit = slave_lsb[3'(26 - fall_cnt)];
    end

    assign SDAin = ReadorWrite ? (Select ? StartStopAck : du_reg[7]) : slave_bit;

    int         cyc = 0;
    int         t_sda_fall = -1;
    int         t_first_fall = -1;
    int         t_last_rise = -1;
    int         t_sda_rise = -1;
    int         sh_addr = 0;
    int         sh_total = 0;
    int         sh_wide = 0;
    int         dv_cycles = 0;
    int         wl_cnt = 0;
    logic [7:0] addr_rx = 8'd0;
    logic       m_ack = 1'b1;
    logic       m_nack = 1'b0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       busy_prev = 1'b0;
    logic       sh_prev = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (WriteLoad) begin
            rise_cnt     = 0;
            fall_cnt     = 0;
            sh_addr      = 0;
            sh_total     = 0;
            sh_wide      = 0;
            dv_cycles    = 0;
            addr_rx      = 8'd0;
            m_ack        = 1'b1;
            m_nack       = 1'b0;
            t_sda_fall   = -1;
            t_first_fall = -1;
            t_last_rise  = -1;
            t_sda_rise   = -1;
            wl_cnt++;
        end
        if (SCL && !scl_prev) begin
            rise_cnt++;
            t_last_rise = cyc;
            if (rise_cnt <= 8) addr_rx = {addr_rx[6:0], SDAin};
            if (rise_cnt == 18) m_ack = SDAin;
            if (rise_cnt == 27) m_nack = SDAin;
        end
        if (!SCL && scl_prev) begin
            fall_cnt++;
            if (fall_cnt == 1) t_first_fall = cyc;
        end
        if (!SDAin && sda_prev && SCL && fall_cnt == 0) t_sda_fall = cyc;
        if (SDAin && !sda_prev && SCL && fall_cnt > 0) t_sda_rise = cyc;
        if (ShiftorHold) begin
            sh_total++;
            if (rise_cnt < 9) sh_addr++;
            if (sh_prev) sh_wide++;
        end
        if (DataValid) dv_cycles++;

        if (busy_prev && !Busy) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("temperature", int'(Temperature), int'(mon_e.temp));
                check_val("ack_error", int'(AckError), int'(mon_e.ack_err));
                check_val("dv_cycles", dv_cycles, mon_e.dv);
                if (!mon_e.aborted) begin
                    check_val("write_loads", wl_cnt, 1);
                    check_val("scl_rises", rise_cnt, mon_e.rises);
                    check_val("shift_total", sh_total, mon_e.sh);
                    check_val("shift_addr", sh_addr, 8);
                    check_val("shift_wide", sh_wide, 0);
                    check_val("addr_byte", int'(addr_rx), 'h91);
                    check_val("start_seen", int'(t_sda_fall >= 0), 1);
                    check_val("start_hold_min", int'((t_first_fall - t_sda_fall) >= HALF), 1);
                    check_val("stop_delay", t_sda_rise - t_last_rise, HALF + 2);
                    check_val("scl_parked", int'(SCL), 1);
                    if (!mon_e.ack_err) begin
                        check_val("master_ack", int'(m_ack), 0);
                        check_val("master_nack", int'(m_nack), 1);
                    end
                end
            end
            wl_cnt = 0;
        end
        scl_prev  = SCL;
        sda_prev  = SDAin;
        busy_prev = Busy;
        sh_prev   = ShiftorHold;
    end

    logic [11:0] last_temp = 12'd0;

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // mode: 0 plain, 1 keep Go high, 2 pulse Go while busy, 3 reset during READ_MSB
    task automatic run_read(input logic ack, input logic [7:0] msb, input logic [7:0] lsb,
                            input int mode);
        exp_t e;
        int   n;
        int   idle_wl;
        int   idle_dv;
        slave_ack = ack;
        slave_msb = msb;
        slave_lsb = lsb;
        e.temp    = ack ? {msb, lsb[7:4]} : last_temp;
        e.ack_err = ~ack;
        e.dv      = ack ? 1 : 0;
        e.rises   = ack ? 28 : 10;
        e.sh      = ack ? 24 : 8;
        e.aborted = 1'b0;
        if (mode == 3) begin
            e.temp    = 12'd0;
            e.ack_err = 1'b0;
            e.dv      = 0;
            e.aborted = 1'b1;
        end
        sb_q.push_back(e);

        @(negedge clock);
        Go = 1'b1;
        n  = 0;
        while (!WriteLoad && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_val("go_to_writeload", n, 2);
        while (!BaudEnable && n < HALF + 20) begin
            @(negedge clock);
            n++;
        end
        check_val("go_to_baud_enable", n, HALF + 2);
        if (mode != 1) Go = 1'b0;

        if (mode == 2) begin
            n = 0;
            while (rise_cnt < 5 && n < 4000) begin
                @(negedge clock);
                n++;
            end
            Go = 1'b1;
            repeat (3) @(negedge clock);
            Go = 1'b0;
        end
        if (mode == 3) begin
            n = 0;
            while (rise_cnt < 12 && n < 4000) begin
                @(negedge clock);
                n++;
            end
            Reset = 1'b1;
            @(negedge clock);
            Reset = 1'b0;
            check_val("rst_baud_enable", int'(BaudEnable), 0);
            check_val("rst_select", int'(Select), 1);
            check_val("rst_start_stop_ack", int'(StartStopAck), 1);
            check_val("rst_read_write", int'(ReadorWrite), 1);
            check_val("rst_busy", int'(Busy), 0);
            repeat (3) @(negedge clock);
            check_val("rst_scl_high", int'(SCL), 1);
        end

        n = 0;
        while (Busy && n < 6000) begin
            @(negedge clock);
            n++;
        end
        if (Busy) begin
            check_val("busy_timeout", int'(Busy), 0);
            finish_run();
        end
        last_temp = e.temp;

        idle_wl = 0;
        idle_dv = 0;
        repeat (3 * HALF) begin
            @(negedge clock);
            if (WriteLoad) idle_wl++;
            if (DataValid) idle_dv++;
        end
        check_val("idle_no_restart", idle_wl, 0);
        check_val("idle_no_valid", idle_dv, 0);
        check_val("ack_error_held", int'(AckError), int'(e.ack_err));
        check_val("temperature_held", int'(Temperature), int'(e.temp));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        Go    = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge clock);
        check_val("reset_busy", int'(Busy), 0);
        check_val("reset_baud_enable", int'(BaudEnable), 0);
        check_val("reset_select", int'(Select), 1);
        check_val("reset_read_write", int'(ReadorWrite), 1);
        check_val("reset_start_stop_ack", int'(StartStopAck), 1);
        check_val("reset_temperature", int'(Temperature), 0);
        check_val("reset_data_valid", int'(DataValid), 0);
        check_val("reset_ack_error", int'(AckError), 0);
        check_val("reset_write_load", int'(WriteLoad), 0);
        check_val("reset_shift", int'(ShiftorHold), 0);
        Reset = 1'b0;
        repeat (5) @(negedge clock);

        run_read(1'b1, 8'h19, 8'h40, 0);
        run_read(1'b1, 8'hA5, 8'h3C, 0);
        run_read(1'b1, 8'($urandom), 8'($urandom), 0);
        run_read(1'b0, 8'h55, 8'hAA, 0);
        run_read(1'b1, 8'h7F, 8'hF0, 1);
        Go = 1'b0;
        repeat (5) @(negedge clock);
        run_read(1'b1, 8'h80, 8'h00, 0);
        run_read(1'b1, 8'h32, 8'h10, 2);
        run_read(1'b1, 8'h19, 8'h40, 3);
        repeat (5) @(negedge clock);
        run_read(1'b1, 8'hE7, 8'h90, 0);

        check_val("sb_drained", sb_q.size(), 0);
        finish_run();
    end

endmodule
